muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 9 +
 rtl/muldiv_seq.sv | 118 +++++++++++
 tb/tb_muldiv_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, controller states and iteration count for muldiv_seq
package muldiv_pkg;
   localparam int ITER = 32;
   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_DIVU  = 2'b01;
   localparam logic [1:0] OP_MTHI  = 2'b10;
   localparam logic [1:0] OP_MTLO  = 2'b11;
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32-bit unsigned multiply/divide unit with HI/LO registers
module muldiv_seq
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        rd_req,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   state_t state, state_n;
   logic [5:0]  cnt, cnt_n;
   logic [31:0] opa, opa_n, opb, opb_n, hi_n, lo_n;
   logic [63:0] acc, acc_n;
   logic [32:0] sum, shl, diff;
   logic        done_n, dbz_n, last;
   assign busy  = state != IDLE;
   assign stall = busy & (start | rd_req);
   // acc is the product in MUL and holds the remainder in its low half in DIV
   always_comb begin
      sum     = {1'b0, acc[63:32]} + (opb[0] ? {1'b0, opa} : 33'd0);
      shl     = {acc[31:0], opa[31]};
      diff    = shl - {1'b0, opb};
      last    = cnt == 6'(ITER - 1);
      state_n = state;
      cnt_n   = cnt;
      opa_n   = opa;
      opb_n   = opb;
      acc_n   = acc;
      hi_n    = hi;
      lo_n    = lo;
      done_n  = 1'b0;
      dbz_n   = 1'b0;
      case (state)
         IDLE: if (start) begin
            case (op)
               OP_MULTU: begin
                  opa_n   = a;
                  opb_n   = b;
                  acc_n   = '0;
                  cnt_n   = '0;
                  state_n = MUL;
               end
               OP_DIVU: if (b != '0) begin
                  opa_n   = a;
                  opb_n   = b;
                  acc_n   = '0;
                  cnt_n   = '0;
                  state_n = DIV;
               end else begin
                  hi_n   = a;
                  lo_n   = '1;
                  done_n = 1'b1;
                  dbz_n  = 1'b1;
               end
               OP_MTHI: hi_n = a;
               default: lo_n = a;
            endcase
         end
         MUL: begin
            acc_n = {sum, acc[31:1]};
            opb_n = opb >> 1;
            cnt_n = cnt + 6'd1;
            if (last) begin
               hi_n    = acc_n[63:32];
               lo_n    = acc_n[31:0];
               done_n  = 1'b1;
               cnt_n   = '0;
               state_n = IDLE;
            end
         end
         DIV: begin
            acc_n = {32'd0, diff[32] ? shl[31:0] : diff[31:0]};
            opa_n = {opa[30:0], ~diff[32]};
            cnt_n = cnt + 6'd1;
            if (last) begin
               hi_n    = acc_n[31:0];
               lo_n    = opa_n;
               done_n  = 1'b1;
               cnt_n   = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         opa         <= '0;
         opb         <= '0;
         acc         <= '0;
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         opa         <= opa_n;
         opb         <= opb_n;
         acc         <= acc_n;
         hi          <= hi_n;
         lo          <= lo_n;
         done        <= done_n;
         div_by_zero <= dbz_n;
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq; expected HI/LO queued at issue, compared on done
module tb_muldiv_seq;
   import muldiv_pkg::*;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, rd_req = 1'b0;
   logic [1:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        busy, stall, done, div_by_zero;
   logic [31:0] hi, lo;
   int errors = 0, checks = 0;
   logic [31:0] cur_hi = '0, cur_lo = '0;
   typedef struct {logic [31:0] hi; logic [31:0] lo; logic dbz;} exp_t;
   exp_t sb[$];
   muldiv_seq dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .rd_req(rd_req),
      .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (div_by_zero && !done) check("dbz_without_done", 1, 0);
      if (done) begin
         if (sb.size() == 0) check("unexpected_done", 1, 0);
         else begin
            e = sb.pop_front();
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
            check("div_by_zero", div_by_zero, e.dbz);
         end
      end
   end
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic wait_done(input int exp_busy);
      int bc = 0;
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (done) seen = 1;
         else begin
            if (busy) bc++;
            @(negedge clk);
         end
      end
      check("done_seen", seen, 1);
      check("busy_cycles", bc, exp_busy);
      check("busy_in_done", busy, 0);
   endtask
   task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      logic [63:0] p;
      p = 64'(x) * 64'(y);
      if (o == OP_MULTU) e = '{p[63:32], p[31:0], 1'b0};
      else if (y == 0) e = '{x, 32'hFFFF_FFFF, 1'b1};
      else e = '{x % y, x / y, 1'b0};
      sb.push_back(e);
      cur_hi = e.hi;
      cur_lo = e.lo;
      issue(o, x, y);
      wait_done((o == OP_DIVU && y == 0) ? 0 : ITER);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int bc;
      logic [31:0] x, y;
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dbz", div_by_zero, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      rst = 1'b0;
      @(negedge clk);
      run(OP_MULTU, 32'd2, 32'd4);
      run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(OP_DIVU, 32'd100, 32'd7);
      run(OP_DIVU, 32'd5, 32'd0);
      run(OP_DIVU, 32'd3, 32'd7);
      run(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
      for (int i = 0; i < 3; i++) begin
         x = $urandom; y = $urandom;
         run(OP_MULTU, x, y);
         x = $urandom; y = $urandom >> $urandom_range(0, 31);
         if (y == 0) y = 32'd1;
         run(OP_DIVU, x, y);
      end
      @(negedge clk);
      sb.push_back('{32'd0, 32'd15, 1'b0});
      issue(OP_MULTU, 32'd3, 32'd5);
      repeat (9) @(negedge clk);
      rd_req = 1'b1;
      #1;
      check("stall_rd", stall, 1);
      check("hold_hi", hi, cur_hi);
      check("hold_lo", lo, cur_lo);
      op = OP_DIVU; a = 32'd9; b = 32'd2; start = 1'b1;
      #1;
      check("stall_start", stall, 1);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         check("stall_busy", stall, 1);
         check("hold_hi_busy", hi, cur_hi);
         @(negedge clk);
      end
      check("done_after_stall", done, 1);
      check("stall_in_done", stall, 0);
      rd_req = 1'b0;
      cur_hi = 32'd0; cur_lo = 32'd15;
      bc = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy) bc++;
      end
      check("ignored_start_busy", bc, 0);
      op = OP_MTHI; a = 32'hDEAD_BEEF; start = 1'b1;
      @(negedge clk);
      check("mthi_done", done, 0);
      op = OP_MTLO; a = 32'h1234_5678;
      @(negedge clk);
      start = 1'b0;
      check("mt_done", done, 0);
      check("mthi", hi, 32'hDEAD_BEEF);
      check("mtlo", lo, 32'h1234_5678);
      issue(OP_DIVU, 32'd1000, 32'd3);
      repeat (15) @(negedge clk);
      check("div_busy_mid", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_hi", hi, 0);
      check("abort_lo", lo, 0);
      bc = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy) bc++;
      end
      check("abort_idle", bc, 0);
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
